// File: rtl/leaf_stream_fifo.sv
// Elastic first-word-fall-through stream FIFO with ap_vld/ap_ack handshakes on both sides.
// Optional statistics outputs are enabled with `define LEAF_STREAM_FIFO_STATS_EN.
module leaf_stream_fifo #(
    parameter int PAYLOAD_BITS       = 32,
    parameter int DEPTH_BITS         = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    input  logic                    flush,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_ap_vld,
    input  logic                    dout_ap_ack,
    output logic [DEPTH_BITS:0]     level,
`ifdef LEAF_STREAM_FIFO_STATS_EN
    output logic [31:0]             stall_cycles,
    output logic [DEPTH_BITS:0]     peak_level,
`endif
    output logic                    almost_full
);

    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] PTR_ONE  = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0] AF_LEVEL = (DEPTH_BITS+1)'(DEPTH - ALMOST_FULL_MARGIN);

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [PAYLOAD_BITS-1:0] dout_last;
    logic [DEPTH_BITS:0]     wr_ptr;
    logic [DEPTH_BITS:0]     rd_ptr;
    logic [DEPTH_BITS:0]     wr_ptr_nxt;
    logic [DEPTH_BITS:0]     rd_ptr_nxt;
    logic [DEPTH_BITS-1:0]   rd_addr;
    logic                    empty;
    logic                    full;
    logic                    push;
    logic                    pop;

    assign rd_addr = rd_ptr[DEPTH_BITS-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                     (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);

    // Including reset keeps the ack low the instant reset asserts, before any edge.
    assign ack_user2interface = vld_interface2user && !full && !flush && reset;
    assign push               = ack_user2interface;
    assign pop                = !empty && dout_ap_ack && !flush;

    assign dout_ap_vld = !empty;
    assign dout        = empty ? dout_last : mem[rd_addr];
    assign almost_full = (level >= AF_LEVEL);

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = rd_ptr;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

    // Storage and the held output word carry no reset; only control is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_BITS-1:0]] <= din_leaf_interface2user;
        if (!empty) dout_last <= mem[rd_addr];
    end

`ifdef LEAF_STREAM_FIFO_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            peak_level   <= '0;
        end else begin
            if (vld_interface2user && !ack_user2interface && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (level > peak_level)
                peak_level <= level;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Randomised and directed bench for leaf_stream_fifo against a queue-based reference model.
// Statistics checks are compiled in when LEAF_STREAM_FIFO_STATS_EN is defined.
module tb_leaf_stream_fifo;

    localparam int PB = 32;
    localparam int DB = 4;
    localparam int DEPTH = 16;
    localparam int AF_MARGIN = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [PB-1:0] din;
    logic          vld;
    logic          ack;
    logic          flush;
    logic [PB-1:0] dout;
    logic          dout_ap_vld;
    logic          dout_ap_ack;
    logic [DB:0]   level;
    logic          almost_full;
`ifdef LEAF_STREAM_FIFO_STATS_EN
    logic [31:0]   stall_cycles;
    logic [DB:0]   peak_level;
`endif

    leaf_stream_fifo #(
        .PAYLOAD_BITS(PB),
        .DEPTH_BITS(DB),
        .ALMOST_FULL_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din_leaf_interface2user(din),
        .vld_interface2user(vld),
        .ack_user2interface(ack),
        .flush(flush),
        .dout(dout),
        .dout_ap_vld(dout_ap_vld),
        .dout_ap_ack(dout_ap_ack),
        .level(level),
`ifdef LEAF_STREAM_FIFO_STATS_EN
        .stall_cycles(stall_cycles),
        .peak_level(peak_level),
`endif
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q[$];
    logic        last_ack;
    int          m_stall = 0;
    int          m_peak = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        logic exp_ack;
        @(negedge clk);
        exp_ack = vld && (q.size() < DEPTH) && !flush;
        check_val("ack", 32'(ack), 32'(exp_ack));
        check_val("dout_vld", 32'(dout_ap_vld), 32'(q.size() != 0));
        if (q.size() != 0) check_val("dout", dout, q[0]);
        check_val("level", 32'(level), 32'(q.size()));
        check_val("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - AF_MARGIN));
`ifdef LEAF_STREAM_FIFO_STATS_EN
        check_val("stall_cycles", stall_cycles, 32'(m_stall));
        check_val("peak_level", 32'(peak_level), 32'(m_peak));
`endif
        @(posedge clk);
        if (vld && !exp_ack) m_stall++;
        if (q.size() > m_peak) m_peak = q.size();
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && dout_ap_ack) void'(q.pop_front());
            if (exp_ack) q.push_back(din);
        end
        last_ack = exp_ack;
        #1;
    endtask

    initial begin
        int pushed;
        int cyc;
        logic offering;

        reset = 1'b0; vld = 1'b0; din = '0; flush = 1'b0; dout_ap_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_vld", 32'(dout_ap_vld), 32'd0);
        reset = 1'b1;
        step();

        // Single word
        vld = 1'b1; din = 32'hDEADBEEF;
        step();
        check_val("single_ack", 32'(last_ack), 32'd1);
        vld = 1'b0;
        step();
        dout_ap_ack = 1'b1;
        step();
        dout_ap_ack = 1'b0;
        step();
        check_val("single_empty", 32'(level), 32'd0);

        // Fill to full, then offer a 17th word
        for (int i = 0; i < DEPTH; i++) begin
            vld = 1'b1; din = 32'(i);
            step();
        end
        din = 32'h0000_0100;
        step();
        check_val("full_level", 32'(level), 32'd16);

        // Full with simultaneous pop: no push this cycle, push accepted the next
        dout_ap_ack = 1'b1;
        step();
        check_val("full_pop_level", 32'(level), 32'd15);
        step();
        check_val("after_full_level", 32'(level), 32'd15);
        vld = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();

        // Random streaming across pointer wrap
        pushed = 0; cyc = 0; offering = 1'b0;
        din = $urandom;
        while (pushed < 100 && cyc < 3000) begin
            if (!offering) vld = ($urandom_range(0, 3) != 0);
            offering = vld;
            dout_ap_ack = ($urandom_range(0, 2) != 0);
            step();
            check_val("level_bound", 32'(level <= 5'd16), 32'd1);
            if (last_ack) begin
                pushed++;
                offering = 1'b0;
                din = $urandom;
            end
            cyc++;
        end
        check_val("rand_pushed", 32'(pushed), 32'd100);
        vld = 1'b0; dout_ap_ack = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        step();
        check_val("rand_drained", 32'(level), 32'd0);

        // Flush with an offer and a pop in the same cycle
        dout_ap_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1; din = 32'h1000 + 32'(i);
            step();
        end
        vld = 1'b1; din = 32'h2000; dout_ap_ack = 1'b1; flush = 1'b1;
        step();
        check_val("flush_ack", 32'(last_ack), 32'd0);
        flush = 1'b0; vld = 1'b0; dout_ap_ack = 1'b0;
        step();
        check_val("flush_level", 32'(level), 32'd0);

        // Push one word, then assert reset mid-cycle while offering another
        vld = 1'b1; din = 32'h3000;
        step();
        din = 32'h3001;
        #3;
        reset = 1'b0;
        #1;
        check_val("rstmid_ack", 32'(ack), 32'd0);
        check_val("rstmid_vld", 32'(dout_ap_vld), 32'd0);
        check_val("rstmid_level", 32'(level), 32'd0);
        check_val("rstmid_af", 32'(almost_full), 32'd0);
`ifdef LEAF_STREAM_FIFO_STATS_EN
        check_val("rstmid_stall", stall_cycles, 32'd0);
        check_val("rstmid_peak", 32'(peak_level), 32'd0);
`endif
        q.delete(); m_stall = 0; m_peak = 0;
        repeat (2) @(posedge clk);
        #1;
        vld = 1'b0;
        reset = 1'b1;
        step();
        check_val("rst_release_level", 32'(level), 32'd0);

        // Fill, then hold an offer for 4 cycles at full
        for (int i = 0; i < DEPTH; i++) begin
            vld = 1'b1; din = 32'h4000 + 32'(i);
            step();
        end
        repeat (4) step();
        vld = 1'b0;
        step();
`ifdef LEAF_STREAM_FIFO_STATS_EN
        check_val("stats_stall", stall_cycles, 32'd4);
        check_val("stats_peak", 32'(peak_level), 32'd16);
`endif
        dout_ap_ack = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();
        check_val("final_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/leaf_stream_fifo.md
Name: leaf_stream_fifo

Overview:
- Elastic stream buffer between a leaf interface's user-side output port and the HLS operator that consumes it.
- Uses ap_vld/ap_ack handshakes on both sides.
- Absorbs bursts from the interface while the operator stalls, so the interface's BRAM slots are released promptly.
- One instance per interface output port, sitting inside the operator wrapper.

Parameters:
- PAYLOAD_BITS, 32, data word width; matches the interface payload width.
- DEPTH_BITS, 4, log2 of FIFO depth (default depth 16 words).
- ALMOST_FULL_MARGIN, 2, the almost_full flag asserts when free entries are at or below this value.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  asynchronous, active-low (0 = in reset); deassertion is synchronised to clk by the wrapper.
- din_leaf_interface2user  input  PAYLOAD_BITS  data word from the leaf interface.
- vld_interface2user  input  1  din valid; held with stable data until acked.
- ack_user2interface  output  1  word accepted this cycle.
- flush  input  1  synchronous discard of all stored words.
- dout  output  PAYLOAD_BITS  head-of-FIFO word to the operator.
- dout_ap_vld  output  1  dout valid.
- dout_ap_ack  input  1  operator consumes dout this cycle.
- level  output  DEPTH_BITS+1  current occupancy, 0..2^DEPTH_BITS.
- almost_full  output  1  occupancy >= 2^DEPTH_BITS - ALMOST_FULL_MARGIN.

Behaviour:
- Transfer rule, both sides: a word moves on a rising clk edge where vld=1 and ack=1.
- Input side:
  - ack_user2interface = vld_interface2user && !full && !flush && reset.
  - The ack path is combinational and does not depend on dout_ap_ack, so it is registered-path safe.
- Output side (first-word-fall-through):
  - dout_ap_vld = !empty.
  - dout = mem[rd_ptr] whenever dout_ap_vld=1; dout is don't-care when empty but is held at its last value.
  - Pop when dout_ap_vld && dout_ap_ack. dout_ap_ack while empty is ignored.
- Latency: a word written at edge N is presented on dout/dout_ap_vld after edge N, i.e. 1 cycle. There is no same-cycle bypass when empty.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_BITS+1 bits wide.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and lower bits are equal.
  - Pointers wrap naturally at 2^(DEPTH_BITS+1).
- level = wr_ptr - rd_ptr, modulo 2^(DEPTH_BITS+1); it is a registered output updated with the pointers.
- Simultaneous push and pop:
  - Not full and not empty: both happen and level is unchanged.
  - Full: no push is allowed that cycle (ack=0 even though a pop frees a slot); the pop proceeds and level decrements by 1.
  - Empty: pop is ignored, push proceeds, level goes to 1.
- flush=1 at an edge:
  - wr_ptr <= rd_ptr, level <= 0, dout_ap_vld=0 the following cycle.
  - Any input offered that cycle is not acked.
  - Any pop that cycle is discarded.
- Reset asserted, including mid-transfer:
  - Immediately forces wr_ptr=0, rd_ptr=0, level=0, dout_ap_vld=0, almost_full=0, ack_user2interface=0.
  - Memory contents are not cleared.
  - A word being offered during reset is not acked and remains the interface's responsibility.
- Memory:
  - 2^DEPTH_BITS x PAYLOAD_BITS register array (distributed RAM), write port on the push condition.
  - The combinational read address is rd_ptr[DEPTH_BITS-1:0].
- No state machine beyond pointer and flag control; all flags derive from registered pointers.

Optional Feature:
- Macro: LEAF_STREAM_FIFO_STATS_EN.
- When defined:
  - Adds output stall_cycles[31:0] and output peak_level[DEPTH_BITS:0].
  - stall_cycles increments on every cycle with vld_interface2user=1 and ack_user2interface=0, saturating at 32'hFFFFFFFF.
  - peak_level is a registered running maximum of level.
  - Both clear on reset; flush does not clear them.
- When undefined: neither port nor register exists, and the core behaviour is identical.

Test Plan:
- Single word: vld=1, din=32'hDEADBEEF, dout_ap_ack=0 -> ack high 1 cycle; next cycle dout=32'hDEADBEEF, dout_ap_vld=1, level=1; assert dout_ap_ack -> level=0, dout_ap_vld=0 next cycle.
- Fill to full: push 0..15 with dout_ap_ack=0 -> level=16, almost_full high from level 14, ack=0 on the 17th offer; drain -> words 0..15 in order.
- Full with simultaneous pop: level=16, vld=1 and dout_ap_ack=1 -> no push, level=15; the following cycle the push is accepted, level=15.
- Pointer wrap: 100 words streamed with random vld/ack gaps -> output sequence equals input sequence, level never exceeds 16 or underflows.
- Flush and reset: level=5, pulse flush -> level=0, dout_ap_vld=0; then push 1 word and assert reset mid-stream -> all outputs 0 immediately, and after release level=0.
- With LEAF_STREAM_FIFO_STATS_EN: hold vld=1 for 4 cycles at full -> stall_cycles=4, peak_level=16.
